// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage: FSM state codes, the
// NOP encoding used for IF/ID bubbles, and the sequential PC increment.
package fetch_pkg;

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] HELD  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response handshake between the fetch stage
// (master) and a variable-latency instruction memory (slave).
interface fetch_stage_if #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned INSTR_W = 32
) ();

   logic               ImemReq;
   logic [PC_W-1:0]    ImemAddr;
   logic [INSTR_W-1:0] ImemRdata;
   logic               ImemValid;

   modport master (
      output ImemReq,
      output ImemAddr,
      input  ImemRdata,
      input  ImemValid
   );

   modport slave (
      input  ImemReq,
      input  ImemAddr,
      output ImemRdata,
      output ImemValid
   );

endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register slice: synchronous clear, stall-hold, and bubble
// (load all-zero) inputs, in that priority order.
module if_id_reg #(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             clear_i,
   input  logic             stall_i,
   input  logic             bubble_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] data_q;

   always_ff @(posedge clk) begin
      if (clear_i) begin
         data_q <= '0;
      end else if (stall_i) begin
         data_q <= data_q;
      end else if (bubble_i) begin
         data_q <= '0;
      end else begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns PCF, drives the instruction-memory
// handshake, and feeds the IF/ID register; wrong-path fetches become bubbles.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned     PC_W     = 32,
   parameter int unsigned     INSTR_W  = 32,
   parameter logic [PC_W-1:0] PC_RESET = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               StallF,
   input  logic               StallD,
   input  logic               PCSrcD,
   input  logic [PC_W-1:0]    PCBranchD,
   fetch_stage_if.master      imem,
   output logic [PC_W-1:0]    PCF,
   output logic [INSTR_W-1:0] InstrD,
   output logic [PC_W-1:0]    PCPlus4D,
   output logic               ValidD
);

   logic [1:0]         state_q, state_d;
   logic [PC_W-1:0]    pcf_q, pcf_d;
   logic [PC_W-1:0]    old_addr_q, old_addr_d;
   logic [INSTR_W-1:0] buf_q, buf_d;

   logic               avail, redirect, consume;
   logic [INSTR_W-1:0] data;
   logic [PC_W-1:0]    pc_plus4;

   assign pc_plus4 = pcf_q + PC_W'(PC_STEP);
   assign avail    = ((state_q == FETCH) && imem.ImemValid) || (state_q == HELD);
   assign data     = (state_q == HELD) ? buf_q : imem.ImemRdata;
   assign redirect = PCSrcD && !StallD;
   assign consume  = avail && !StallF && !StallD && !redirect;

   assign imem.ImemReq  = !reset && ((state_q == FETCH) || (state_q == DRAIN));
   assign imem.ImemAddr = (state_q == DRAIN) ? old_addr_q : pcf_q;

   always_comb begin
      state_d    = state_q;
      pcf_d      = pcf_q;
      old_addr_d = old_addr_q;
      buf_d      = buf_q;
      if (redirect) begin
         pcf_d = PCBranchD;
         if ((state_q == FETCH) && !imem.ImemValid) begin
            // Request already issued to the old address; must absorb its response.
            old_addr_d = pcf_q;
            state_d    = DRAIN;
         end else if (state_q != DRAIN) begin
            state_d = FETCH;
         end
      end else if (consume) begin
         pcf_d   = pc_plus4;
         state_d = FETCH;
      end else if ((state_q == FETCH) && imem.ImemValid && StallF) begin
         buf_d   = imem.ImemRdata;
         state_d = HELD;
      end else if ((state_q == DRAIN) && imem.ImemValid) begin
         state_d = FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         pcf_q      <= PC_RESET;
         old_addr_q <= '0;
         buf_q      <= '0;
      end else begin
         state_q    <= state_d;
         pcf_q      <= pcf_d;
         old_addr_q <= old_addr_d;
         buf_q      <= buf_d;
      end
   end

   assign PCF = pcf_q;

   localparam int unsigned IfIdW = 1 + PC_W + INSTR_W;

   logic [IfIdW-1:0] if_id_d, if_id_q;

   assign if_id_d = consume ? {1'b1, pc_plus4, data} : {1'b0, {PC_W{1'b0}}, INSTR_W'(NOP_INSTR)};

   if_id_reg #(
      .Width (IfIdW)
   ) u_if_id_reg (
      .clk      (clk),
      .clear_i  (reset),
      .stall_i  (StallD),
      .bubble_i (!consume),
      .d_i      (if_id_d),
      .q_o      (if_id_q)
   );

   assign {ValidD, PCPlus4D, InstrD} = if_id_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a programmable-wait-state instruction memory.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        StallF, StallD, PCSrcD;
   logic [31:0] PCBranchD;
   logic [31:0] PCF, InstrD, PCPlus4D;
   logic        ValidD;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_stage_if #(.PC_W(32), .INSTR_W(32)) imem ();

   fetch_stage #(
      .PC_W     (32),
      .INSTR_W  (32),
      .PC_RESET (32'h0000_0000)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .StallF    (StallF),
      .StallD    (StallD),
      .PCSrcD    (PCSrcD),
      .PCBranchD (PCBranchD),
      .imem      (imem),
      .PCF       (PCF),
      .InstrD    (InstrD),
      .PCPlus4D  (PCPlus4D),
      .ValidD    (ValidD)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h0: rom = 32'h2008_0005;
         32'h4: rom = 32'h2009_0007;
         32'h8: rom = 32'h0109_5020;
         32'hC: rom = 32'h012A_5820;
         default: rom = a ^ 32'hA5A5_0000;
      endcase
   endfunction

   // Memory model: response arrives after w_states extra cycles of ImemReq.
   int unsigned w_states = 0;
   logic [31:0] mem_cnt;
   always @(posedge clk) begin
      if (reset || imem.ImemValid) mem_cnt <= 32'd0;
      else if (imem.ImemReq)       mem_cnt <= mem_cnt + 32'd1;
   end
   assign imem.ImemValid = imem.ImemReq && (mem_cnt == w_states);
   assign imem.ImemRdata = imem.ImemValid ? rom(imem.ImemAddr) : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                           input logic v);
      chk({tag, ".InstrD"}, InstrD, ins);
      chk({tag, ".PCPlus4D"}, PCPlus4D, p4);
      chk({tag, ".ValidD"}, {31'b0, ValidD}, {31'b0, v});
   endtask

   // Address must not move while a request is outstanding.
   logic        out_q = 1'b0;
   logic [31:0] addr_q;
   always @(posedge clk) begin
      out_q  <= imem.ImemReq && !imem.ImemValid;
      addr_q <= imem.ImemAddr;
   end
   always @(negedge clk) begin
      if (out_q && imem.ImemReq) chk("addr_stable", imem.ImemAddr, addr_q);
      if (StallF !== StallD) begin
         $display("FAIL stall_pair StallF=%b StallD=%b", StallF, StallD);
         $fatal(1, "illegal stall combination");
      end
   end

   initial begin
      reset = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'h0;
      step();
      chk("rst.req", {31'b0, imem.ImemReq}, 32'd0);
      step();
      chk("rst.PCF", PCF, 32'h0);
      chk_ifid("rst", 32'h0, 32'h0, 1'b0);

      // Zero-wait streaming.
      reset = 1'b0;
      #1;
      chk("s0.req", {31'b0, imem.ImemReq}, 32'd1);
      chk("s0.addr", imem.ImemAddr, 32'h0);
      step();
      chk("s1.addr", imem.ImemAddr, 32'h4);
      chk_ifid("s1", 32'h2008_0005, 32'h4, 1'b1);
      step();
      chk("s2.addr", imem.ImemAddr, 32'h8);
      chk_ifid("s2", 32'h2009_0007, 32'h8, 1'b1);

      // Stall two cycles while the 0x8 response arrives.
      StallF = 1'b1; StallD = 1'b1;
      step();
      chk("st1.req", {31'b0, imem.ImemReq}, 32'd0);
      chk("st1.PCF", PCF, 32'h8);
      chk_ifid("st1", 32'h2009_0007, 32'h8, 1'b1);
      step();
      chk("st2.req", {31'b0, imem.ImemReq}, 32'd0);
      chk_ifid("st2", 32'h2009_0007, 32'h8, 1'b1);
      StallF = 1'b0; StallD = 1'b0;
      step();
      chk_ifid("rel", 32'h0109_5020, 32'hC, 1'b1);
      chk("rel.addr", imem.ImemAddr, 32'hC);
      chk("rel.req", {31'b0, imem.ImemReq}, 32'd1);

      // Zero-wait redirect: same-cycle data from 0xC dropped.
      PCSrcD = 1'b1; PCBranchD = 32'h40;
      step();
      PCSrcD = 1'b0;
      chk("br.addr", imem.ImemAddr, 32'h40);
      chk_ifid("br", 32'h0, 32'h0, 1'b0);
      step();
      chk_ifid("br1", 32'hA5A5_0040, 32'h44, 1'b1);

      // Redirect to 0x10, then 3-cycle memory with a redirect mid-request.
      PCSrcD = 1'b1; PCBranchD = 32'h10;
      step();
      PCSrcD = 1'b0; w_states = 2;
      chk("d0.addr", imem.ImemAddr, 32'h10);
      PCSrcD = 1'b1; PCBranchD = 32'h40;
      step();
      PCSrcD = 1'b0;
      chk("d1.addr", imem.ImemAddr, 32'h10);
      chk("d1.req", {31'b0, imem.ImemReq}, 32'd1);
      chk("d1.PCF", PCF, 32'h40);
      chk("d1.valid", {31'b0, ValidD}, 32'd0);
      step();
      chk("d2.addr", imem.ImemAddr, 32'h10);
      chk("d2.valid", {31'b0, ValidD}, 32'd0);
      step();
      chk("d3.addr", imem.ImemAddr, 32'h40);
      chk("d3.valid", {31'b0, ValidD}, 32'd0);
      step();
      chk("d4.valid", {31'b0, ValidD}, 32'd0);
      step();
      chk("d5.valid", {31'b0, ValidD}, 32'd0);
      step();
      chk_ifid("d6", 32'hA5A5_0040, 32'h44, 1'b1);

      // Redirect under stall is ignored, then taken once the stall drops.
      w_states = 0;
      StallF = 1'b1; StallD = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h80;
      step();
      chk("sr.PCF", PCF, 32'h44);
      chk_ifid("sr", 32'hA5A5_0040, 32'h44, 1'b1);
      StallF = 1'b0; StallD = 1'b0;
      step();
      PCSrcD = 1'b0;
      chk("sr1.PCF", PCF, 32'h80);
      chk_ifid("sr1", 32'h0, 32'h0, 1'b0);
      step();
      chk_ifid("sr2", 32'hA5A5_0080, 32'h84, 1'b1);

      // Reset in the middle of DRAIN.
      w_states = 2;
      PCSrcD = 1'b1; PCBranchD = 32'hC0;
      step();
      PCSrcD = 1'b0;
      chk("rd.addr", imem.ImemAddr, 32'h84);
      reset = 1'b1;
      #1;
      chk("rd.req", {31'b0, imem.ImemReq}, 32'd0);
      step();
      reset = 1'b0;
      chk("rd.PCF", PCF, 32'h0);
      chk("rd.valid", {31'b0, ValidD}, 32'd0);
      #1;
      chk("rd.addr0", imem.ImemAddr, 32'h0);
      w_states = 0;
      step();
      chk_ifid("rd1", 32'h2008_0005, 32'h4, 1'b1);

      // PC wrap at the top of the address space.
      PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
      step();
      PCSrcD = 1'b0;
      chk("wr.PCF", PCF, 32'hFFFF_FFFC);
      step();
      chk("wr1.PCF", PCF, 32'h0);
      chk_ifid("wr1", 32'h5A5A_FFFC, 32'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. It sits directly upstream of decode and consumes the hazard unit's StallF, StallD and the decode-resolved branch redirect (PCSrcD/PCBranchD). It owns PCF and a variable-latency instruction-memory request handshake. Wrong-path and not-yet-returned fetches become bubbles, marked by ValidD=0.

Parameters:
PC_RESET, 32'h0000_0000, PCF value after reset.
PC_W, 32, PC and address width.
INSTR_W, 32, instruction width.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high.
StallF  input  1  hold PCF and the fetch buffer (from hazard unit).
StallD  input  1  hold IF/ID (from hazard unit); must equal StallF.
PCSrcD  input  1  taken branch/jump resolved in decode.
PCBranchD  input  PC_W  redirect target.
ImemReq  output  1  request valid; held until ImemValid.
ImemAddr  output  PC_W  request address; stable while ImemReq=1 and ImemValid=0.
ImemRdata  input  INSTR_W  instruction; sampled only when ImemValid=1.
ImemValid  input  1  response; may assert in the same cycle as ImemReq (zero-wait).
PCF  output  PC_W  current fetch PC.
InstrD  output  INSTR_W  IF/ID instruction.
PCPlus4D  output  PC_W  IF/ID PC+4.
ValidD  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (sync, high): PCF=PC_RESET, state=FETCH, InstrD=0, PCPlus4D=0, ValidD=0, buffer cleared, pending redirect cleared. ImemReq forced 0 while reset=1. The memory abandons any outstanding request on reset.
- States:
  - FETCH: ImemReq=1, ImemAddr=PCF.
  - HELD: instruction buffered, ImemReq=0.
  - DRAIN: ImemReq=1, ImemAddr=OldAddr; waiting to discard a wrong-path response.
- avail = (FETCH && ImemValid) || HELD. Data source is ImemRdata in FETCH and the buffer in HELD.
- redirect = PCSrcD && !StallD. PCSrcD is ignored while StallD=1.
- consume = avail && !StallF && !StallD && !redirect.
- PC/state update, in priority order:
  - reset.
  - redirect:
    - FETCH with !ImemValid: OldAddr<=PCF, PCF<=PCBranchD, go DRAIN.
    - DRAIN: PCF<=PCBranchD, stay DRAIN (target overwritten).
    - Otherwise: PCF<=PCBranchD, go FETCH; buffer and any same-cycle ImemRdata are dropped.
  - consume: PCF<=PCF+4 (mod 2^PC_W, so 0xFFFF_FFFC wraps to 0), go FETCH.
  - FETCH && ImemValid && StallF: capture ImemRdata into buffer, go HELD.
  - DRAIN && ImemValid: data dropped, go FETCH at the current PCF.
  - Otherwise: hold.
- IF/ID update, in priority order:
  - reset: clear.
  - StallD: hold all three fields.
  - redirect: InstrD=0 (nop), PCPlus4D=0, ValidD=0.
  - consume: InstrD=data, PCPlus4D=PCF+4, ValidD=1.
  - Otherwise: bubble (InstrD=0, ValidD=0, PCPlus4D=0).
- Latency and throughput: zero-wait memory gives 1 instr/cycle; an instruction appears in IF/ID the cycle after ImemValid. An N-cycle memory inserts N-1 bubbles per instruction.
- Invariants:
  - No instruction is lost or duplicated under any stall pattern.
  - No wrong-path instruction ever has ValidD=1.
  - ImemAddr never changes while a request is outstanding.
- StallF != StallD is illegal; the bench asserts against it.

Decomposition:
- Package fetch_pkg: state enum {FETCH, HELD, DRAIN}, NOP_INSTR=32'h0, PC_STEP=4.
- Sub-module if_id_reg: IF/ID register with stall-hold, clear and bubble inputs. It is reused for later register slices.

Test Plan:
- Reset, zero-wait memory returning 0x20080005, 0x20090007, 0x01095020 -> ImemAddr 0,4,8 on consecutive cycles. InstrD follows in order with PCPlus4D 4,8,C and ValidD=1.
- StallF=StallD=1 for 2 cycles on an ImemValid at PC 0x8 -> HELD, ImemReq=0, IF/ID holds. On release the buffered instr loads with PCPlus4D=0xC, then ImemAddr=0xC; no duplicate.
- PCSrcD=1, PCBranchD=0x40, zero-wait -> next ImemAddr=0x40; InstrD=0 and ValidD=0 for one cycle. Same-cycle data dropped.
- 3-cycle memory, redirect to 0x40 at cycle 1 of a request to 0x10 -> DRAIN. ImemAddr stays 0x10 until ImemValid, then 0x40; ValidD never 1 for the 0x10 data.
- PCSrcD=1 with StallD=1 -> ignored; PCF and IF/ID unchanged. The same redirect taken once StallD drops.
- Reset asserted mid-DRAIN -> next cycle PCF=PC_RESET, state FETCH, ValidD=0. PCF=0xFFFF_FFFC consumed -> PCF wraps to 0.
